// File: rtl/order_fetch_pkg.sv
// Shared definitions for the order_fetch instruction fetch stage.
// Holds the datapath widths, the NOP encoding presented to decode while
// no instruction is available, the fetch FSM state type and a helper
// that word-aligns an address.
package order_fetch_pkg;

    localparam int ORDER_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ORDER_W-1:0] NOP_ORDER = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // The low two bits of a fetch address are always zero.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/order_fetch_fifo.sv
// Prefetch FIFO for order_fetch: synchronous FIFO of {addr, word} entries.
// Ports:
//   clk, rst       clock, synchronous active-low reset (empties the FIFO)
//   push/push_data write one entry (ignored when full or when flushing)
//   pop            remove the head entry (ignored when empty or flushing)
//   flush          discard every entry; overrides push and pop
//   head_data      current head entry, valid while empty=0
//   full/empty     occupancy flags
//   count          number of stored entries, 0..DEPTH
module order_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign full      = (r_count == (PW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    assign w_push_ok = push && !full && !flush;
    assign w_pop_ok  = pop && !empty && !flush;

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/order_fetch.sv
// order_fetch: instruction fetch stage of the 023A soft core.
// Reads 32-bit words from instruction memory into a prefetch FIFO and
// presents one instruction per cycle to decode, holding while decode stalls
// and flushing/redirecting on jumps from later stages.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   mem_req/mem_addr  read request and word-aligned address (held until ack)
//   mem_ack/mem_rdata one-cycle response strobe with the instruction word
//   isStop            decode stall: outputs hold, no pop
//   jump_en/jump_addr redirect strobe and target (low two bits ignored)
//   order             instruction to decode (NOP_ORDER when idle)
//   thisOrderAddress  address of order
//   this_isRunning    1 = order is a real instruction, 0 = bubble
//   o_dbg_state       current fetch FSM state
//
// Memory handshake: mem_req is a level; once raised, mem_addr stays stable
// and mem_req stays high until the cycle mem_ack=1, which completes the
// transfer in that same cycle. mem_ack while mem_req=0 is ignored.
module order_fetch
    import order_fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [ORDER_W-1:0]  mem_rdata,
    input  logic                isStop,
    input  logic                jump_en,
    input  logic [ADDR_W-1:0]   jump_addr,
    output logic [ORDER_W-1:0]  order,
    output logic [ADDR_W-1:0]   thisOrderAddress,
    output logic                this_isRunning,
    output fetch_state_t        o_dbg_state
);

    localparam int          CW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   w_fetch_pc_next;
    logic                r_mem_req;
    logic                w_mem_req_next;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   w_mem_addr_next;
    logic [ADDR_W-1:0]   w_pc_inc;

    logic [ORDER_W-1:0]  r_order;
    logic [ADDR_W-1:0]   r_order_addr;
    logic                r_running;

    logic                          w_push;
    logic                          w_pop;
    logic                          w_full;
    logic                          w_empty;
    logic [CW:0]                   w_count;
    logic [CW:0]                   w_count_after;
    logic [ADDR_W+ORDER_W-1:0]     w_head;

    assign mem_req          = r_mem_req;
    assign mem_addr         = r_mem_addr;
    assign order            = r_order;
    assign thisOrderAddress = r_order_addr;
    assign this_isRunning   = r_running;
    assign o_dbg_state      = r_state;

    // A jump discards the data of any ack in the same cycle.
    assign w_push = (r_state == WAIT) && mem_ack && !jump_en && !w_full;
    assign w_pop  = !jump_en && !isStop && !w_empty;

    // Occupancy once this cycle's push and pop have both landed; used to
    // decide whether a back-to-back request still has a guaranteed slot.
    assign w_count_after = w_count + (CW+1)'(w_push) - (CW+1)'(w_pop);
    assign w_pc_inc      = r_fetch_pc + 32'd4;

    order_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + ORDER_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({r_mem_addr, mem_rdata}),
        .pop       (w_pop),
        .flush     (jump_en),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
        end
    end

    // r_fetch_pc is the address of the request in flight (or the next one
    // to issue); it advances only when a non-discarded word is accepted.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        case (r_state)
            IDLE: begin
                if (jump_en) begin
                    // Stay idle one cycle so the new target is issued next.
                    w_fetch_pc_next = word_align(jump_addr);
                end else if (w_count < DEPTH_C) begin
                    w_state_next    = WAIT;
                    w_mem_req_next  = 1'b1;
                    w_mem_addr_next = r_fetch_pc;
                end
            end
            WAIT: begin
                if (jump_en) begin
                    w_fetch_pc_next = word_align(jump_addr);
                    if (mem_ack) begin
                        w_state_next   = IDLE;
                        w_mem_req_next = 1'b0;
                    end else begin
                        // The request cannot be withdrawn; wait out its ack.
                        w_state_next = DROP;
                    end
                end else if (mem_ack) begin
                    w_fetch_pc_next = w_pc_inc;
                    if (w_count_after < DEPTH_C) begin
                        w_mem_addr_next = w_pc_inc;
                    end else begin
                        w_state_next   = IDLE;
                        w_mem_req_next = 1'b0;
                    end
                end
            end
            DROP: begin
                if (jump_en) begin
                    w_fetch_pc_next = word_align(jump_addr);
                end
                if (mem_ack) begin
                    w_state_next   = IDLE;
                    w_mem_req_next = 1'b0;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_mem_req_next = 1'b0;
            end
        endcase
    end

    // Decode-facing registers. A jump wins over a stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_order      <= NOP_ORDER;
            r_order_addr <= '0;
            r_running    <= 1'b0;
        end else if (jump_en) begin
            r_order   <= NOP_ORDER;
            r_running <= 1'b0;
        end else if (!isStop) begin
            if (!w_empty) begin
                r_order      <= w_head[ORDER_W-1:0];
                r_order_addr <= w_head[ADDR_W+ORDER_W-1:ORDER_W];
                r_running    <= 1'b1;
            end else begin
                r_order   <= NOP_ORDER;
                r_running <= 1'b0;
            end
        end
    end

endmodule
